muldiv_unit: RTL and testbench

Multi-cycle unsigned multiply/divide execution unit for the 8-bit core. Consumes the two operands read from the 32×8 register file, runs an iterative shift-add multiply or restoring divide, and produces a one-cycle register-file write (enable, address, data) that drives the register file's write port directly. Sits between operand read and register writeback, alongside the single-cycle ALU.

---
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_muldiv_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle unsigned 8-bit multiply/divide unit.
// It takes two register-file operands and runs a shift-add multiply or a
// restoring divide over 8 iterations. The result goes out as a single-cycle
// register-file write.
//
// Ports:
//   clk          - clock; all state updates on the rising edge
//   rst_n        - asynchronous active-low reset
//   start        - operation request, sampled only while idle
//   op           - 00 MUL (low byte), 01 MULHU (high byte), 10 DIVU, 11 REMU
//   operand_a    - multiplicand / dividend
//   operand_b    - multiplier / divisor
//   dest_addr    - destination register (x0 results are discarded)
//   busy         - high whenever an operation is in progress
//   write_enable - one-cycle register-file write strobe
//   write_addr   - register-file write address (holds until next result)
//   write_data   - register-file write data (holds until next result)
module muldiv_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [7:0] operand_a,
    input  logic [7:0] operand_b,
    input  logic [4:0] dest_addr,
    output logic       busy,
    output logic       write_enable,
    output logic [4:0] write_addr,
    output logic [7:0] write_data
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_next;
    logic [1:0]  op_q;
    logic [7:0]  opnd_q;     // multiplicand (MUL*) or divisor (DIV*/REM*)
    logic [4:0]  dest_q;
    logic [2:0]  iter_cnt;
    logic        iter_done;
    logic [15:0] acc;        // MUL: {partial product, multiplier}; DIV: acc[7:0] dividend -> quotient
    logic [7:0]  rem;

    logic [8:0]  mul_sum;
    logic [8:0]  div_trial;
    logic        div_ge;
    logic [7:0]  div_rem_next;
    logic [7:0]  result;

    assign busy = (state != IDLE);

    // Shift-add step: add the multiplicand to the high half when the current
    // multiplier bit is set. The 9-bit sum keeps the carry, which is shifted
    // back into the accumulator.
    always_comb begin
        mul_sum = {1'b0, acc[15:8]} + (acc[0] ? {1'b0, opnd_q} : 9'd0);
    end

    // Restoring divide step: bring down the dividend MSB into the 9-bit
    // partial remainder. A zero divisor always subtracts, so the quotient is
    // all ones and the remainder is the dividend.
    always_comb begin
        div_trial    = {rem, acc[7]};
        div_ge       = (div_trial >= {1'b0, opnd_q});
        div_rem_next = div_ge ? 8'(div_trial - {1'b0, opnd_q}) : div_trial[7:0];
    end

    always_comb begin
        result = acc[7:0];
        case (op_q)
            2'b00:   result = acc[7:0];
            2'b01:   result = acc[15:8];
            2'b10:   result = acc[7:0];
            default: result = rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // CALC holds one extra cycle after the 8th iteration (iter_done). That
    // cycle loads the result, and DONE then issues the write strobe.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (iter_done) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= '0;
            opnd_q       <= '0;
            dest_q       <= '0;
            iter_cnt     <= '0;
            iter_done    <= 1'b0;
            acc          <= '0;
            rem          <= '0;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
        end else begin
            write_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        opnd_q    <= op[1] ? operand_b : operand_a;
                        acc       <= {8'h00, (op[1] ? operand_a : operand_b)};
                        rem       <= '0;
                        dest_q    <= dest_addr;
                        iter_cnt  <= '0;
                        iter_done <= 1'b0;
                    end
                end
                CALC: begin
                    if (!iter_done) begin
                        if (op_q[1]) begin
                            acc[7:0] <= {acc[6:0], div_ge};
                            rem      <= div_rem_next;
                        end else begin
                            acc <= {mul_sum, acc[7:1]};
                        end
                        iter_cnt <= iter_cnt + 3'd1;
                        if (iter_cnt == 3'd7) iter_done <= 1'b1;
                    end else begin
                        write_data <= result;
                        write_addr <= dest_q;
                    end
                end
                DONE: begin
                    write_enable <= (dest_q != 5'd0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit. It drives directed and random
// operations and compares every result with an arithmetic reference model.
// It also checks busy/write_enable timing, start-ignore behaviour, x0
// suppression and asynchronous reset.
module tb_muldiv_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic [4:0] dest_addr;
    logic       busy;
    logic       write_enable;
    logic [4:0] write_addr;
    logic [7:0] write_data;

    int checks   = 0;
    int failures = 0;

    muldiv_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .dest_addr    (dest_addr),
        .busy         (busy),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic on the full product / quotient.
    function automatic logic [7:0] ref_result(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        int unsigned p;
        p = a * b;
        case (o)
            2'b00:   return 8'(p & 32'hFF);
            2'b01:   return 8'((p >> 8) & 32'hFF);
            2'b10:   return (b == 8'd0) ? 8'hFF : 8'(a / b);
            default: return (b == 8'd0) ? a : 8'(a % b);
        endcase
    endfunction

    // Issues one operation and observes 14 cycles at negedges. Sample j is
    // taken after edge Ej (E0 = start sample). Operands are scrambled right
    // after capture. With inject set, start is also re-pulsed at E3 and E10.
    task automatic run_op(input logic [1:0] op_i, input logic [7:0] a_i, input logic [7:0] b_i,
                          input logic [4:0] d_i, input bit inject,
                          output int we_cnt, output int we_at, output int busy_bad,
                          output logic [7:0] data_at, output logic [4:0] addr_at,
                          output logic [7:0] data_end, output logic [4:0] addr_end);
        we_cnt = 0; we_at = -1; busy_bad = 0; data_at = '0; addr_at = '0;
        @(negedge clk);
        op = op_i; operand_a = a_i; operand_b = b_i; dest_addr = d_i; start = 1'b1;
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            if (j == 0) begin
                start = 1'b0;
                op = 2'($urandom); operand_a = 8'($urandom); operand_b = 8'($urandom);
                dest_addr = 5'($urandom);
            end
            if (inject && (j == 2 || j == 9)) begin
                start = 1'b1;
                op = 2'($urandom); operand_a = 8'($urandom); operand_b = 8'($urandom);
                dest_addr = 5'($urandom_range(1, 31));
            end
            if (inject && (j == 3 || j == 10)) start = 1'b0;
            if (busy !== (j <= 9)) busy_bad++;
            if (write_enable === 1'b1) begin
                we_cnt++;
                if (we_at < 0) begin
                    we_at = j; data_at = write_data; addr_at = write_addr;
                end
            end
        end
        start = 1'b0;
        data_end = write_data;
        addr_end = write_addr;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; op = '0; operand_a = '0; operand_b = '0; dest_addr = '0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", write_enable); end
        checks++; if (write_addr !== 5'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", write_addr); end
        checks++; if (write_data !== 8'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", write_data); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [1:0] ops [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11};
        logic [7:0] as  [8] = '{8'd13, 8'd200, 8'd200, 8'd200, 8'd200, 8'd255, 8'h5A, 8'h5A};
        logic [7:0] bs  [8] = '{8'd11, 8'd200, 8'd200, 8'd7, 8'd7, 8'd1, 8'd0, 8'd0};
        logic [7:0] exp [8] = '{8'h8F, 8'h9C, 8'h40, 8'h1C, 8'h04, 8'hFF, 8'hFF, 8'h5A};
        int we_cnt, we_at, busy_bad;
        logic [7:0] d_at, d_end;
        logic [4:0] a_at, a_end, dst;
        for (int i = 0; i < 8; i++) begin
            dst = (i == 0) ? 5'd5 : 5'(i + 10);
            run_op(ops[i], as[i], bs[i], dst, 1'b0, we_cnt, we_at, busy_bad, d_at, a_at, d_end, a_end);
            checks++; if (d_at !== exp[i]) begin failures++; $display("FAIL dir%0d_data got=%h exp=%h", i, d_at, exp[i]); end
            checks++; if (a_at !== dst) begin failures++; $display("FAIL dir%0d_addr got=%h exp=%h", i, a_at, dst); end
            checks++; if (we_cnt !== 1) begin failures++; $display("FAIL dir%0d_we_count got=%0d exp=1", i, we_cnt); end
            checks++; if (we_at !== 10) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=10", i, we_at); end
            checks++; if (busy_bad !== 0) begin failures++; $display("FAIL dir%0d_busy bad_cycles=%0d exp=0", i, busy_bad); end
            checks++; if (d_end !== exp[i] || a_end !== dst) begin
                failures++; $display("FAIL dir%0d_hold got=%h/%h exp=%h/%h", i, d_end, a_end, exp[i], dst);
            end
        end
    endtask

    task automatic test_random;
        int we_cnt, we_at, busy_bad;
        logic [7:0] d_at, d_end, a, b, e;
        logic [4:0] a_at, a_end, dst;
        logic [1:0] o;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom);
            a = 8'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            dst = 5'($urandom_range(1, 31));
            e = ref_result(o, a, b);
            run_op(o, a, b, dst, 1'b0, we_cnt, we_at, busy_bad, d_at, a_at, d_end, a_end);
            checks++; if (d_at !== e || we_at !== 10 || we_cnt !== 1) begin
                failures++;
                $display("FAIL rand%0d op=%0d a=%h b=%h data got=%h exp=%h we_at=%0d we_cnt=%0d", i, o, a, b, d_at, e, we_at, we_cnt);
            end
            checks++; if (a_at !== dst || busy_bad !== 0) begin
                failures++; $display("FAIL rand%0d_addr_busy addr got=%h exp=%h busy_bad=%0d", i, a_at, dst, busy_bad);
            end
        end
    endtask

    task automatic test_ignore_start;
        int we_cnt, we_at, busy_bad;
        logic [7:0] d_at, d_end;
        logic [4:0] a_at, a_end;
        run_op(2'b00, 8'h21, 8'h07, 5'd9, 1'b1, we_cnt, we_at, busy_bad, d_at, a_at, d_end, a_end);
        checks++; if (we_cnt !== 1) begin failures++; $display("FAIL ignore_we_count got=%0d exp=1", we_cnt); end
        checks++; if (d_at !== 8'hE7 || a_at !== 5'd9) begin
            failures++; $display("FAIL ignore_result got=%h/%h exp=e7/09", d_at, a_at);
        end
        checks++; if (busy_bad !== 0) begin failures++; $display("FAIL ignore_busy bad_cycles=%0d exp=0", busy_bad); end
    endtask

    task automatic test_x0;
        int we_cnt, we_at, busy_bad;
        logic [7:0] d_at, d_end;
        logic [4:0] a_at, a_end;
        run_op(2'b00, 8'd9, 8'd9, 5'd0, 1'b0, we_cnt, we_at, busy_bad, d_at, a_at, d_end, a_end);
        checks++; if (we_cnt !== 0) begin failures++; $display("FAIL x0_we_count got=%0d exp=0", we_cnt); end
        checks++; if (busy_bad !== 0) begin failures++; $display("FAIL x0_busy bad_cycles=%0d exp=0", busy_bad); end
    endtask

    task automatic test_mid_reset;
        int we_cnt, we_at, busy_bad, pulses;
        logic [7:0] d_at, d_end;
        logic [4:0] a_at, a_end;
        @(negedge clk);
        op = 2'b00; operand_a = 8'd50; operand_b = 8'd60; dest_addr = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || write_enable !== 1'b0) begin
            failures++; $display("FAIL midrst_ctrl busy=%b we=%b exp=0/0", busy, write_enable);
        end
        checks++; if (write_addr !== 5'd0 || write_data !== 8'd0) begin
            failures++; $display("FAIL midrst_data got=%h/%h exp=00/00", write_addr, write_data);
        end
        pulses = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (j == 1) rst_n = 1'b1;
            if (write_enable === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL midrst_no_pulse got=%0d exp=0", pulses); end
        run_op(2'b00, 8'd3, 8'd4, 5'd7, 1'b0, we_cnt, we_at, busy_bad, d_at, a_at, d_end, a_end);
        checks++; if (d_at !== 8'h0C || a_at !== 5'd7 || we_cnt !== 1 || we_at !== 10) begin
            failures++; $display("FAIL post_reset_mul got=%h/%h we_cnt=%0d we_at=%0d exp=0c/07/1/10", d_at, a_at, we_cnt, we_at);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_x0();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
